// File: rtl/vec_ram_arbiter_pkg.sv
// vec_ram_arbiter_pkg: shared state, grant encodings and width defaults for the vector RAM arbiter
package vec_ram_arbiter_pkg;
  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
  localparam logic GNT_EX = 1'b0;
  localparam logic GNT_HOST = 1'b1;
endpackage

// File: rtl/vec_ram_cycle.sv
// vec_ram_cycle: one async SRAM access per go (address setup, WAIT_STATES strobe cycles, hold)
module vec_ram_cycle
  import vec_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dq_out,
  output logic              ram_dq_oe,
  input  logic [DATA_W-1:0] ram_dq_in,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);
  localparam int CW = $clog2(WAIT_STATES) + 1;
  if (WAIT_STATES < 1) begin : g_bad_wait
    $error("WAIT_STATES must be >= 1");
  end
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      cnt <= (state == SETUP) ? CW'(WAIT_STATES) : (state == STROBE) ? cnt - CW'(1) : cnt;
      if (state == IDLE && go) begin
        we_q <= we;
        addr_q <= addr;
        wdata_q <= wdata;
      end
      if (state == STROBE && cnt == CW'(1) && !we_q) rdata <= ram_dq_in;
    end
  end
  // Read data is sampled on the last strobe edge, so oe_n spans SETUP and STROBE.
  always_comb begin
    state_nx = (state == IDLE) ? (go ? SETUP : IDLE) :
               (state == SETUP) ? STROBE :
               (state == STROBE) ? ((cnt == CW'(1)) ? DONE : STROBE) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
    ram_ce_n = !busy;
    ram_oe_n = !(!we_q && (state == SETUP || state == STROBE));
    ram_we_n = !(we_q && state == STROBE);
    ram_dq_oe = we_q && busy;
    ram_addr = addr_q;
    ram_dq_out = wdata_q;
  end
endmodule

// File: rtl/vec_ram_arbiter.sv
// vec_ram_arbiter: shares the vector SRAM between the executor (read-only) and the host loader,
// blocking host writes while a run is active.
module vec_ram_arbiter
  import vec_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exec_active,
  input  logic              ex_req,
  input  logic [ADDR_W-1:0] ex_addr,
  output logic              ex_ack,
  output logic [DATA_W-1:0] ex_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_err,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dq_out,
  output logic              ram_dq_oe,
  input  logic [DATA_W-1:0] ram_dq_in,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              busy
);
  logic go, done, rej, rej_q, host_ok, gnt, gnt_nx, gnt_we, cyc_we, last_grant;
  logic [ADDR_W-1:0] cyc_addr;
  logic [DATA_W-1:0] rdata, ex_data_q, host_rdata_q;
  // A host request seen in its own reject-ack cycle is stale, not a new request.
  always_comb begin
    host_ok = host_req && !rej_q;
    go = !busy && (ex_req || (host_ok && !(exec_active && host_we)));
    rej = !busy && exec_active && !ex_req && host_ok && host_we;
    gnt_nx = (!exec_active && ex_req && host_ok) ? ~last_grant : (ex_req ? GNT_EX : GNT_HOST);
    cyc_we = gnt_nx == GNT_HOST && host_we;
    cyc_addr = (gnt_nx == GNT_HOST) ? host_addr : ex_addr;
    ex_ack = done && gnt == GNT_EX;
    host_ack = (done && gnt == GNT_HOST) || rej_q;
    host_err = rej_q;
    ex_data = ex_ack ? rdata : ex_data_q;
    host_rdata = (done && gnt == GNT_HOST && !gnt_we) ? rdata : host_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt <= GNT_EX;
      gnt_we <= 1'b0;
      last_grant <= GNT_HOST;
      rej_q <= 1'b0;
      ex_data_q <= '0;
      host_rdata_q <= '0;
    end else begin
      rej_q <= rej;
      ex_data_q <= ex_data;
      host_rdata_q <= host_rdata;
      if (go) begin
        gnt <= gnt_nx;
        gnt_we <= cyc_we;
      end
      if (done) last_grant <= gnt;
    end
  end
  vec_ram_cycle #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .WAIT_STATES(WAIT_STATES)
  ) u_cycle (
    .clk(clk),
    .reset(reset),
    .go(go),
    .we(cyc_we),
    .addr(cyc_addr),
    .wdata(host_wdata),
    .done(done),
    .busy(busy),
    .rdata(rdata),
    .ram_addr(ram_addr),
    .ram_dq_out(ram_dq_out),
    .ram_dq_oe(ram_dq_oe),
    .ram_dq_in(ram_dq_in),
    .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n)
  );
endmodule

// File: tb/tb_vec_ram_arbiter.sv
// tb_vec_ram_arbiter: directed scenarios against a cycle-phase reference model and an SRAM model
module tb_vec_ram_arbiter;
  localparam int WS = 2;
  localparam int DN = WS + 2;
  logic clk = 0, reset = 1, exec_active = 0, ex_req = 0, host_req = 0, host_we = 0;
  logic [23:0] ex_addr = 0, host_addr = 0, ram_addr;
  logic [7:0] host_wdata = 0, ex_data, host_rdata, ram_dq_out, ram_dq_in;
  logic ex_ack, host_ack, host_err, ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n, busy;
  logic [7:0] dev_mem [0:255] = '{default: 8'h00};
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  vec_ram_arbiter #(.ADDR_W(24), .DATA_W(8), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .exec_active(exec_active),
    .ex_req(ex_req), .ex_addr(ex_addr), .ex_ack(ex_ack), .ex_data(ex_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_dq_out(ram_dq_out), .ram_dq_oe(ram_dq_oe), .ram_dq_in(ram_dq_in),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .busy(busy)
  );
  assign ram_dq_in = (!ram_ce_n && !ram_oe_n) ? dev_mem[ram_addr[7:0]] : 8'h00;
  always @(posedge clk) if (!ram_ce_n && !ram_we_n && ram_dq_oe) dev_mem[ram_addr[7:0]] <= ram_dq_out;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Reference: ph counts cycles since grant (0 = idle); memory effects applied at transaction level.
  int ph = 0;
  logic m_gnt = 0, m_we = 0, last_g = 1, m_rej = 0, started = 0;
  logic [23:0] m_addr = 0;
  logic [7:0] m_wd = 0, m_exd = 0, m_hd = 0;
  logic [7:0] ref_mem [0:255] = '{default: 8'h00};
  always @(negedge clk) begin : model
    int g;
    logic h, nrej;
    if (started) begin
      chk("busy", busy, ph != 0);
      chk("ce_n", ram_ce_n, ph == 0);
      chk("oe_n", ram_oe_n, !(ph >= 1 && ph <= WS + 1 && !m_we));
      chk("we_n", ram_we_n, !(ph >= 2 && ph <= WS + 1 && m_we));
      chk("dq_oe", ram_dq_oe, ph != 0 && m_we);
      chk("ram_addr", ram_addr, m_addr);
      if (ph != 0 && m_we) chk("dq_out", ram_dq_out, m_wd);
      chk("ex_ack", ex_ack, ph == DN && !m_gnt);
      chk("host_ack", host_ack, (ph == DN && m_gnt) || m_rej);
      chk("host_err", host_err, m_rej);
      chk("ex_data", ex_data, m_exd);
      chk("host_rdata", host_rdata, m_hd);
      chk("oe_conflict", ram_dq_oe && !ram_oe_n, 0);
    end
    nrej = 0;
    g = -1;
    if (reset) begin
      ph = 0; m_gnt = 0; m_we = 0; last_g = 1; m_addr = 0; m_wd = 0; m_exd = 0; m_hd = 0; started = 1;
    end else if (ph == 0) begin
      h = host_req && !m_rej;
      if (exec_active) begin
        if (ex_req) g = 0;
        else if (h && !host_we) g = 1;
        else if (h) nrej = 1;
      end else if (ex_req && h) g = last_g ? 0 : 1;
      else if (ex_req) g = 0;
      else if (h) g = 1;
      if (g >= 0) begin
        ph = 1;
        m_gnt = (g == 1);
        m_we = (g == 1) && host_we;
        m_addr = (g == 1) ? host_addr : ex_addr;
        m_wd = host_wdata;
      end
    end else if (ph == DN) begin
      last_g = m_gnt;
      if (m_we) ref_mem[m_addr[7:0]] = m_wd;
      ph = 0;
    end else begin
      if (ph == DN - 1 && !m_we) begin
        if (m_gnt) m_hd = ref_mem[m_addr[7:0]];
        else m_exd = ref_mem[m_addr[7:0]];
      end
      ph++;
    end
    m_rej = nrej;
  end
  task automatic access(input logic is_ex, input logic we, input logic [23:0] a, input logic [7:0] d,
                        output int lat, output int n_we, output int n_oe, output int n_dq, output int n_ce,
                        output logic err, output logic [7:0] rd);
    @(posedge clk); #1;
    if (is_ex) begin ex_req = 1; ex_addr = a; end
    else begin host_req = 1; host_we = we; host_addr = a; host_wdata = d; end
    lat = -1; n_we = 0; n_oe = 0; n_dq = 0; n_ce = 0; err = 0; rd = 0;
    for (int c = 0; c < 30 && lat < 0; c++) begin
      @(negedge clk);
      n_we += int'(!ram_we_n);
      n_oe += int'(!ram_oe_n);
      n_dq += int'(ram_dq_oe);
      n_ce += int'(!ram_ce_n);
      if (is_ex ? ex_ack : host_ack) begin
        lat = c;
        err = host_err;
        rd = is_ex ? ex_data : host_rdata;
      end
    end
    @(posedge clk); #1;
    ex_req = 0;
    host_req = 0;
    if (lat < 0) chk("ack_timeout", 0, 1);
  endtask
  initial begin
    int lat, n_we, n_oe, n_dq, n_ce, nacks, seq, hacks;
    int t[4];
    logic err;
    logic [7:0] rd;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_dq_oe, busy}, 5'b11100);
    chk("rst_addr_dq", {ram_addr, ram_dq_out}, 0);
    chk("rst_outputs", {ex_ack, host_ack, host_err, ex_data, host_rdata}, 0);
    access(0, 1, 24'h000010, 8'hA5, lat, n_we, n_oe, n_dq, n_ce, err, rd);
    chk("wr_latency", lat, 4);
    chk("wr_we_low", n_we, 2);
    chk("wr_dq_oe", n_dq, 4);
    chk("wr_err", err, 0);
    access(1, 0, 24'h000010, 8'h00, lat, n_we, n_oe, n_dq, n_ce, err, rd);
    chk("rd_latency", lat, 4);
    chk("rd_data", rd, 8'hA5);
    chk("rd_oe_low", n_oe, 3);
    chk("rd_dq_oe", n_dq, 0);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    ex_req = 1; ex_addr = 24'h000010; host_req = 1; host_we = 0; host_addr = 24'h000010;
    nacks = 0; seq = 0;
    for (int c = 0; c < 40 && nacks < 4; c++) begin
      @(negedge clk);
      if (ex_ack || host_ack) begin
        t[nacks] = c;
        seq = seq * 2 + int'(host_ack);
        nacks++;
      end
    end
    @(posedge clk); #1 ex_req = 0; host_req = 0;
    chk("rr_acks", nacks, 4);
    chk("rr_order", seq, 4'b0101);
    chk("rr_first", t[0], 4);
    chk("rr_spacing", {t[1] - t[0], t[2] - t[1], t[3] - t[2]}, {32'd5, 32'd5, 32'd5});
    chk("rr_data", {ex_data, host_rdata}, 16'hA5A5);
    exec_active = 1;
    access(0, 1, 24'h000020, 8'h3C, lat, n_we, n_oe, n_dq, n_ce, err, rd);
    chk("rej_latency", lat, 1);
    chk("rej_err", err, 1);
    chk("rej_no_ram", n_ce, 0);
    exec_active = 0;
    access(0, 0, 24'h000020, 8'h00, lat, n_we, n_oe, n_dq, n_ce, err, rd);
    chk("rej_readback", rd, 8'h00);
    exec_active = 1;
    @(posedge clk); #1;
    ex_req = 1; ex_addr = 24'h000020; host_req = 1; host_we = 0; host_addr = 24'h000010;
    nacks = 0; hacks = 0;
    for (int c = 0; c < 60 && nacks < 3; c++) begin
      @(negedge clk);
      nacks += int'(ex_ack);
      hacks += int'(host_ack);
    end
    @(posedge clk); #1 ex_req = 0;
    chk("prio_ex_acks", nacks, 3);
    chk("prio_host_held", hacks, 0);
    lat = -1;
    for (int c = 0; c < 30 && lat < 0; c++) begin
      @(negedge clk);
      if (host_ack) begin lat = c; err = host_err; rd = host_rdata; end
    end
    @(posedge clk); #1 host_req = 0; exec_active = 0;
    chk("prio_host_lat", lat, 4);
    chk("prio_host_err", err, 0);
    chk("prio_host_data", rd, 8'hA5);
    host_req = 1; host_we = 1; host_addr = 24'h000030; host_wdata = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1; host_req = 0;
    @(negedge clk);
    chk("mid_strobe_we", ram_we_n, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("mid_rst_idle", {ram_ce_n, ram_oe_n, ram_we_n, ram_dq_oe, busy}, 5'b11100);
    hacks = int'(host_ack);
    repeat (10) begin
      @(negedge clk);
      hacks += int'(host_ack);
    end
    chk("mid_rst_no_ack", hacks, 0);
    access(0, 1, 24'hFFFFFF, 8'h5A, lat, n_we, n_oe, n_dq, n_ce, err, rd);
    access(0, 0, 24'hFFFFFF, 8'h00, lat, n_we, n_oe, n_dq, n_ce, err, rd);
    chk("top_addr_data", rd, 8'h5A);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vec_ram_arbiter.md
Name: vec_ram_arbiter

Overview:
- Shares the single vector RAM (24-bit address, 8-bit data, async SRAM) between two requesters.
- Requester 1 is the executor: read-only, fetches test vectors during a run.
- Requester 2 is the host loader: read/write, used for upload and readback.
- Generates the SRAM strobe timing and protects vector memory from host writes while a test is executing.

Parameters:
- ADDR_W, 24: RAM address width.
- DATA_W, 8: RAM data width.
- WAIT_STATES, 2: strobe cycles per access; must be >= 1, elaboration error otherwise.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- exec_active  in  1  executor run in progress.
- ex_req  in  1  executor read request, level.
- ex_addr  in  ADDR_W  executor read address.
- ex_ack  out  1  one-cycle pulse: read complete.
- ex_data  out  DATA_W  executor read data.
- host_req  in  1  host request, level.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  one-cycle pulse: access done or rejected.
- host_err  out  1  pulse with host_ack when a write is rejected.
- host_rdata  out  DATA_W  host read data.
- ram_addr  out  ADDR_W  SRAM address.
- ram_dq_out  out  DATA_W  SRAM write data.
- ram_dq_oe  out  1  SRAM data driver enable.
- ram_dq_in  in  DATA_W  SRAM read data.
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - ram_ce_n = ram_oe_n = ram_we_n = 1.
  - ram_dq_oe = 0; ram_addr = 0; ram_dq_out = 0.
  - acks = 0; host_err = 0; ex_data = host_rdata = 0.
  - busy = 0; last_grant = host, so the executor wins the first tie.
- Reset mid-access: next edge deasserts all strobes and returns to IDLE; no ack is issued.
- FSM: IDLE -> SETUP -> STROBE (WAIT_STATES cycles, down-counter of width clog2(WAIT_STATES)+1) -> DONE -> IDLE.
- Requests are sampled only in IDLE.
- Address, write data and host_we are registered at grant and stay stable until DONE.
- Arbitration in IDLE:
  - exec_active = 1:
    - ex_req has absolute priority.
    - host read is served only when ex_req = 0.
    - host write is rejected: host_ack = host_err = 1 for one cycle, next cycle, with no RAM cycle and FSM staying in IDLE.
  - exec_active = 0: round-robin on simultaneous requests (grant the requester != last_grant); a single requester is granted directly.
- SETUP:
  - ram_addr valid, ram_ce_n = 0.
  - Read: ram_oe_n = 0.
  - Write: ram_dq_oe = 1, ram_we_n stays 1 (address setup).
- STROBE:
  - Read: ram_oe_n = 0.
  - Write: ram_we_n = 0.
  - On the last STROBE edge, a read captures ram_dq_in into the granted requester's data register.
- DONE:
  - ram_we_n = ram_oe_n = 1; ce_n, addr and dq_oe held (hold time).
  - Granted requester's ack = 1; last_grant updated.
- Latency: req sampled in IDLE at cycle 0 -> ack high in cycle WAIT_STATES+2.
- Minimum back-to-back period: WAIT_STATES+3 cycles.
- Requester protocol: keep req high until ack. If req is still high the cycle after ack, it is treated as a new request.
- ex_data and host_rdata hold their value until the next read for the same requester completes.
- exec_active changing mid-access: the current access completes unchanged; the new value affects only the next arbitration.
- ram_dq_oe and ram_oe_n are never both active.
- Address width: no wrap logic; the address is passed through unchanged.

Decomposition:
- Shared include parameters file holds:
  - FSM state encodings (IDLE/SETUP/STROBE/DONE).
  - ADDR_W / DATA_W defaults.
  - grant encodings GNT_EX = 0, GNT_HOST = 1.
- One sub-module, vec_ram_cycle: SETUP/STROBE/DONE strobe sequencer with wait counter. Inputs: go, we, addr, wdata. Outputs: done pulse, rdata.
- Arbitration stays in the top module.

Test Plan:
- Reset, then host write 0xA5 @0x000010 (exec_active = 0, WAIT_STATES = 2) -> ram_we_n low exactly 2 cycles, dq_oe high for 4 cycles, host_ack in cycle 4, host_err = 0.
- Executor read @0x000010 with model returning 0xA5 -> ex_data = 0xA5 at ex_ack (cycle 4), ram_oe_n low 3 cycles, dq_oe never high.
- ex_req and host_req (read) raised together, both held, exec_active = 0 -> grants alternate ex, host, ex, host; ack spacing 5 cycles.
- exec_active = 1, host write @0x000020 -> host_ack = host_err = 1 next cycle; no strobe activity; RAM content unchanged on readback.
- exec_active = 1, ex_req held continuously plus host read pending -> host served only after ex_req drops; no host_err.
- reset asserted during STROBE of a write -> next cycle all strobes high, dq_oe = 0, busy = 0, no ack ever issued for that access.
